// File: rtl/axi4lite_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: turns a valid/ready command port into AXI4-Lite
// transactions. Optional watchdog enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi4lite_cmd_master #(
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            busy,
    output logic                            bus_timeout,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned SW = C_M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {StIdle, StWrAwW, StWrB, StRdAr, StRdR, StRsp} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic            write_q, write_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      resp_q, resp_d;
    logic            aw_hs, w_hs;

    // All bus outputs decode from registered state, so they change only after a clock edge.
    assign cmd_ready     = (state_q == StIdle);
    assign busy          = (state_q != StIdle);
    assign rsp_valid     = (state_q == StRsp);
    assign rsp_write     = write_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_AWVALID = (state_q == StWrAwW) && !aw_done_q;
    assign M_AXI_WVALID  = (state_q == StWrAwW) && !w_done_q;
    assign M_AXI_BREADY  = (state_q == StWrB);
    assign M_AXI_ARVALID = (state_q == StRdAr);
    assign M_AXI_RREADY  = (state_q == StRdR);

    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        write_d   = write_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    write_d   = cmd_write;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_write ? StWrAwW : StRdAr;
                end
            end
            StWrAwW: begin
                // AW and W complete independently; move on once both have handshaken.
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = StWrB;
            end
            StWrB: begin
                if (M_AXI_BVALID) begin
                    resp_d  = M_AXI_BRESP;
                    rdata_d = '0;
                    state_d = StRsp;
                end
            end
            StRdAr: begin
                if (M_AXI_ARREADY) state_d = StRdR;
            end
            StRdR: begin
                if (M_AXI_RVALID) begin
                    rdata_d = M_AXI_RDATA;
                    resp_d  = M_AXI_RRESP;
                    state_d = StRsp;
                end
            end
            StRsp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            write_q   <= write_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            tmo_q, tmo_d;
    logic            in_bus;

    assign in_bus      = (state_q inside {StWrAwW, StWrB, StRdAr, StRdR});
    assign bus_timeout = tmo_q;

    // Watchdog only flags a stuck slave; the transaction itself keeps waiting.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_d     = tmo_q;
        if (state_d != state_q) begin
            tmo_cnt_d = '0;
        end else if (in_bus && (tmo_cnt_q != TmoW'(TIMEOUT_CYCLES))) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        if (in_bus && (tmo_cnt_d == TmoW'(TIMEOUT_CYCLES))) tmo_d = 1'b1;
        if (cmd_valid && cmd_ready) tmo_d = 1'b0;
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo  = ^TIMEOUT_CYCLES;
    assign bus_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi4lite_cmd_master.sv
// Bench for axi4lite_cmd_master: memory-backed AXI4-Lite slave with per-channel delays,
// directed vector table, corner-case sequences and randomized traffic against a memory model.
module tb_axi4lite_cmd_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy, bus_timeout;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = 32'h0;

    always #5 clk = ~clk;

    axi4lite_cmd_master #(
        .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_ADDR_WIDTH(32),
        .TIMEOUT_CYCLES    (16)
    ) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESET (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_write    (rsp_write),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .busy         (busy),
        .bus_timeout  (bus_timeout),
        .M_AXI_AWADDR (awaddr),
        .M_AXI_AWPROT (awprot),
        .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA  (wdata),
        .M_AXI_WSTRB  (wstrb),
        .M_AXI_WVALID (wvalid),
        .M_AXI_WREADY (wready),
        .M_AXI_BRESP  (bresp),
        .M_AXI_BVALID (bvalid),
        .M_AXI_BREADY (bready),
        .M_AXI_ARADDR (araddr),
        .M_AXI_ARPROT (arprot),
        .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA  (rdata),
        .M_AXI_RRESP  (rresp),
        .M_AXI_RVALID (rvalid),
        .M_AXI_RREADY (rready)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] s);
        for (int i = 0; i < 4; i++) if (s[i]) o[8*i +: 8] = d[8*i +: 8];
        return o;
    endfunction

    // Slave configuration and state
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [1:0]  resp_val;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit          aw_got, w_got, ar_got;
    bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;
    logic [31:0] smem [logic [31:0]];
    logic [31:0] rmem [logic [31:0]];
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    int          n_aw, n_w, n_b, n_ar, n_r;
    int          cyc = 0;
    int          acc_cyc;

    // Handshake recorder and payload-stability checks at the active edge.
    always @(posedge clk) begin
        cyc++;
        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
        b_hs  = bvalid && bready;
        ar_hs = arvalid && arready;
        r_hs  = rvalid && rready;
        if (awvalid) begin
            check("awaddr", awaddr, exp_addr);
            check("awprot", awprot, 3'b000);
        end
        if (wvalid) begin
            check("wdata", wdata, exp_wdata);
            check("wstrb", wstrb, exp_wstrb);
        end
        if (arvalid) begin
            check("araddr", araddr, exp_addr);
            check("arprot", arprot, 3'b000);
        end
        if (aw_hs) begin n_aw++; cap_awaddr = awaddr; end
        if (w_hs)  begin n_w++;  cap_wdata = wdata; cap_wstrb = wstrb; end
        if (ar_hs) begin n_ar++; cap_araddr = araddr; end
        if (b_hs)  n_b++;
        if (r_hs)  n_r++;
    end

    // Slave drives its outputs on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_got = 0; w_got = 0; ar_got = 0;
            aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        end else begin
            if (aw_hs) begin
                awready = 0; aw_got = 1; aw_cnt = 0;
                check("awvalid_drop", awvalid, 1'b0);
            end else if (awvalid) begin
                awready = (aw_cnt >= aw_dly); aw_cnt++;
            end
            if (w_hs) begin
                wready = 0; w_got = 1; w_cnt = 0;
                check("wvalid_drop", wvalid, 1'b0);
            end else if (wvalid) begin
                wready = (w_cnt >= w_dly); w_cnt++;
            end
            if (ar_hs) begin
                arready = 0; ar_got = 1; ar_cnt = 0;
                check("arvalid_drop", arvalid, 1'b0);
            end else if (arvalid) begin
                arready = (ar_cnt >= ar_dly); ar_cnt++;
            end
            if (b_hs) begin
                bvalid = 0; aw_got = 0; w_got = 0; b_cnt = 0;
            end else if (aw_got && w_got && !bvalid) begin
                if (b_cnt >= b_dly) begin
                    bvalid = 1; bresp = resp_val;
                    smem[cap_awaddr] = merge(smem.exists(cap_awaddr) ? smem[cap_awaddr] : 32'h0,
                                             cap_wdata, cap_wstrb);
                end else b_cnt++;
            end
            if (r_hs) begin
                rvalid = 0; ar_got = 0; r_cnt = 0;
            end else if (ar_got && !rvalid) begin
                if (r_cnt >= r_dly) begin
                    rvalid = 1; rresp = resp_val;
                    rdata = smem.exists(cap_araddr) ? smem[cap_araddr] : 32'h0;
                end else r_cnt++;
            end
        end
    end

    task automatic send_cmd(input bit w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input bit hold);
        int n;
        @(negedge clk);
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        exp_addr = a; exp_wdata = d; exp_wstrb = s;
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        check("cmd_ready", cmd_ready, 1'b1);
        acc_cyc = cyc;
        @(posedge clk);
        #1 cmd_valid = hold;
    endtask

    task automatic get_rsp(input bit w, input logic [31:0] rd, input logic [1:0] resp,
                           input int lat, input int hold_cyc);
        int n;
        @(negedge clk);
        n = 1;
        while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
        check("rsp_valid", rsp_valid, 1'b1);
        check("latency", cyc - acc_cyc, lat);
        check("rsp_write", rsp_write, w);
        check("rsp_rdata", rsp_rdata, rd);
        check("rsp_resp", rsp_resp, resp);
        if (w) begin
            check("n_aw", n_aw, 1); check("n_w", n_w, 1); check("n_b", n_b, 1);
        end else begin
            check("n_ar", n_ar, 1); check("n_r", n_r, 1);
        end
        for (int i = 0; i < hold_cyc; i++) begin
            @(negedge clk);
            check("rsp_hold_valid", rsp_valid, 1'b1);
            check("rsp_hold_rdata", rsp_rdata, rd);
            check("rsp_hold_resp", rsp_resp, resp);
            check("rsp_hold_cmd_ready", cmd_ready, 1'b0);
        end
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
    endtask

    typedef struct {
        bit          w;
        logic [31:0] a, d;
        logic [3:0]  s;
        int          awd, wd, bd, ard, rd;
        logic [1:0]  resp;
        int          hold;
        logic [31:0] exp_rd;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [31:0] a, d, erd;
        logic [3:0]  s;
        bit          w;
        int          lat;
        bit          exp_to;
        int          n;

        tbl[0] = '{1, 32'h8,  32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 2'b00, 3};
        tbl[1] = '{0, 32'h4,  32'h0, 4'h0, 0, 0, 0, 3, 0, 2'b00, 0, 32'h12345678, 2'b00, 6};
        tbl[2] = '{1, 32'h10, 32'hCAFEF00D, 4'hF, 2, 0, 0, 0, 0, 2'b00, 0, 32'h0, 2'b00, 5};
        tbl[3] = '{1, 32'h14, 32'h01020304, 4'hF, 0, 2, 1, 0, 0, 2'b00, 0, 32'h0, 2'b00, 6};
        tbl[4] = '{0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 5, 32'hCAFEF00D, 2'b00, 3};
        tbl[5] = '{1, 32'h8,  32'h11112222, 4'h3, 0, 0, 0, 0, 0, 2'b10, 0, 32'h0, 2'b10, 3};
        tbl[6] = '{0, 32'h8,  32'h0, 4'h0, 0, 0, 0, 0, 2, 2'b00, 0, 32'hDEAD2222, 2'b00, 5};

        smem[32'h4] = 32'h12345678;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0; resp_val = 2'b00;
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        exp_addr = 0; exp_wdata = 0; exp_wstrb = 0;

        // Reset values
        #1 rst = 1;
        #2;
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_bus_timeout", bus_timeout, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_resp", rsp_resp, 2'b00);
        check("rst_awaddr", awaddr, 32'h0);
        check("rst_wdata", wdata, 32'h0);
        repeat (3) @(negedge clk);
        rst = 0;

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            aw_dly = tbl[i].awd; w_dly = tbl[i].wd; b_dly = tbl[i].bd;
            ar_dly = tbl[i].ard; r_dly = tbl[i].rd; resp_val = tbl[i].resp;
            send_cmd(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, 0);
            get_rsp(tbl[i].w, tbl[i].exp_rd, tbl[i].exp_resp, tbl[i].exp_lat, tbl[i].hold);
        end

        // Held cmd_valid across a stalled response; next command taken right after rsp_ready
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; resp_val = 2'b00;
        send_cmd(0, 32'h14, 32'h0, 4'h0, 1);
        cmd_write = 1; cmd_addr = 32'h18; cmd_wdata = 32'hA5A5A5A5; cmd_wstrb = 4'hF;
        get_rsp(0, 32'h01020304, 2'b00, 3, 5);
        exp_addr = 32'h18; exp_wdata = 32'hA5A5A5A5; exp_wstrb = 4'hF;
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
        @(negedge clk);
        check("held_cmd_ready", cmd_ready, 1'b1);
        acc_cyc = cyc;
        @(posedge clk);
        #1 cmd_valid = 0;
        check("held_busy", busy, 1'b1);
        get_rsp(1, 32'h0, 2'b00, 3, 0);

        // AW stall long enough to trip the watchdog when it is built in
        aw_dly = 40;
        send_cmd(1, 32'h30, 32'h00000055, 4'hF, 0);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
`ifdef AXI_MASTER_TIMEOUT_EN
            exp_to = (k >= 17);
`else
            exp_to = 0;
`endif
            if (k == 16) begin
                check("tmo_before", bus_timeout, exp_to);
                check("tmo_wvalid_done", wvalid, 1'b0);
            end
            if (k == 17) begin
                check("tmo_flag", bus_timeout, exp_to);
                check("tmo_awvalid_held", awvalid, 1'b1);
            end
        end
        get_rsp(1, 32'h0, 2'b00, 43, 0);
        check("tmo_sticky", bus_timeout, exp_to);
        aw_dly = 0;
        send_cmd(0, 32'h30, 32'h0, 4'h0, 0);
        check("tmo_clear", bus_timeout, 1'b0);
        get_rsp(0, 32'h00000055, 2'b00, 3, 0);

        // Reset while waiting for R
        r_dly = 30;
        send_cmd(0, 32'h4, 32'h0, 4'h0, 0);
        n = 0;
        while (!rready && n < 20) begin @(negedge clk); n++; end
        check("pre_rst_rready", rready, 1'b1);
        #2 rst = 1;
        #1;
        check("midrst_arvalid", arvalid, 1'b0);
        check("midrst_rready", rready, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_rsp_rdata", rsp_rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("postrst_cmd_ready", cmd_ready, 1'b1);
        check("postrst_busy", busy, 1'b0);

        // Randomized traffic against a memory model
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 32'h100 + 32'($urandom_range(0, 15)) * 4;
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            r_dly = $urandom_range(0, 3);
            resp_val = 2'($urandom_range(0, 3));
            if (w) begin
                rmem[a] = merge(rmem.exists(a) ? rmem[a] : 32'h0, d, s);
                erd = 32'h0;
                lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
            end else begin
                erd = rmem.exists(a) ? rmem[a] : 32'h0;
                lat = 3 + ar_dly + r_dly;
            end
            send_cmd(w, a, d, s, 0);
            get_rsp(w, erd, resp_val, lat, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
